// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/ME memory port arbiter.
//   ARB_*            : arbiter FSM state encodings
//   GNT_*            : grant owner encodings
//   mem_bus_req_t    : latched bus transaction payload (we, be, addr, wdata)
package mem_port_arbiter_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = 4;

  // FSM state encodings
  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_BUS  = 2'd1;
  localparam logic [1:0] ARB_RESP = 2'd2;

  // Grant owner encodings
  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_ME = 1'b1;

  typedef struct packed {
    logic            we;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } mem_bus_req_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between the IF (fetch) and ME (load/store) stages.
//   iClk/nRst            : clock, synchronous active-high reset
//   iIF_*/oIF_*          : fetch request, flush, registered result (data/valid/err)
//   iME_*/oME_*          : load/store request, registered result (rdata/valid/err)
//   oStall_IF/oStall_ME  : combinational stalls to the hazard unit
//   oBus_*/iBus_*        : single-master memory bus with ack/err, timeout abort
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic            iClk,
  input  logic            nRst,
  input  logic            iIF_req,
  input  logic [XLEN-1:0] iIF_addr,
  input  logic            iFlush_IF,
  output logic [XLEN-1:0] oIF_data,
  output logic            oIF_valid,
  output logic            oIF_err,
  output logic            oStall_IF,
  input  logic            iME_req,
  input  logic            iME_we,
  input  logic [BE_W-1:0] iME_be,
  input  logic [XLEN-1:0] iME_addr,
  input  logic [XLEN-1:0] iME_wdata,
  output logic [XLEN-1:0] oME_rdata,
  output logic            oME_valid,
  output logic            oME_err,
  output logic            oStall_ME,
  output logic            oBus_req,
  output logic            oBus_we,
  output logic [BE_W-1:0] oBus_be,
  output logic [XLEN-1:0] oBus_addr,
  output logic [XLEN-1:0] oBus_wdata,
  input  logic            iBus_ack,
  input  logic [XLEN-1:0] iBus_rdata,
  input  logic            iBus_err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]      state_q, state_d;
  logic            grant_q, grant_d;
  mem_bus_req_t    bus_q, bus_d;
  logic            bus_req_q, bus_req_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            flush_q, flush_d;
  logic [XLEN-1:0] if_data_q, if_data_d;
  logic            if_valid_q, if_valid_d;
  logic            if_err_q, if_err_d;
  logic [XLEN-1:0] me_rdata_q, me_rdata_d;
  logic            me_valid_q, me_valid_d;
  logic            me_err_q, me_err_d;

  logic [CNT_W-1:0] cnt_inc;
  logic            timeout;
  logic            resp_err;
  logic [XLEN-1:0] resp_data;
  logic            if_flushed;

  // Timeout fires on the TIMEOUT_CYCLES-th BUS cycle; an ack in that cycle wins.
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) && !iBus_ack;

  // Flush requested now or earlier in this fetch discards its result.
  assign if_flushed = flush_q | iFlush_IF;

  // Next-state, bus latch and response capture
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    bus_d      = bus_q;
    bus_req_d  = bus_req_q;
    cnt_d      = cnt_q;
    flush_d    = flush_q;
    if_data_d  = if_data_q;
    if_valid_d = 1'b0;
    if_err_d   = 1'b0;
    me_rdata_d = me_rdata_q;
    me_valid_d = 1'b0;
    me_err_d   = 1'b0;
    resp_err   = 1'b1;
    resp_data  = '0;

    if (iBus_ack) begin
      resp_err  = iBus_err;
      resp_data = bus_q.we ? '0 : iBus_rdata;
    end

    case (state_q)
      ARB_IDLE: begin
        flush_d = 1'b0;
        // ME is the older instruction, so it wins a simultaneous request.
        if (iME_req) begin
          grant_d     = GNT_ME;
          bus_d.we    = iME_we;
          bus_d.be    = iME_be;
          bus_d.addr  = iME_addr;
          bus_d.wdata = iME_wdata;
          bus_req_d   = 1'b1;
          cnt_d       = '0;
          state_d     = ARB_BUS;
        end else if (iIF_req) begin
          grant_d     = GNT_IF;
          bus_d.we    = 1'b0;
          bus_d.be    = 4'hF;
          bus_d.addr  = iIF_addr;
          bus_d.wdata = '0;
          bus_req_d   = 1'b1;
          cnt_d       = '0;
          state_d     = ARB_BUS;
        end
      end
      ARB_BUS: begin
        cnt_d = cnt_inc;
        if (iFlush_IF && (grant_q == GNT_IF)) flush_d = 1'b1;
        if (iBus_ack || timeout) begin
          bus_req_d = 1'b0;
          state_d   = ARB_RESP;
          if (grant_q == GNT_ME) begin
            me_rdata_d = resp_data;
            me_valid_d = 1'b1;
            me_err_d   = resp_err;
          end else if (!if_flushed) begin
            if_data_d  = resp_data;
            if_valid_d = 1'b1;
            if_err_d   = resp_err;
          end
        end
      end
      ARB_RESP: begin
        flush_d = 1'b0;
        state_d = ARB_IDLE;
      end
      default: begin
        bus_req_d = 1'b0;
        flush_d   = 1'b0;
        state_d   = ARB_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge iClk) begin
    if (nRst) begin
      state_q    <= ARB_IDLE;
      grant_q    <= GNT_IF;
      bus_q      <= '0;
      bus_req_q  <= 1'b0;
      cnt_q      <= '0;
      flush_q    <= 1'b0;
      if_data_q  <= '0;
      if_valid_q <= 1'b0;
      if_err_q   <= 1'b0;
      me_rdata_q <= '0;
      me_valid_q <= 1'b0;
      me_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      bus_q      <= bus_d;
      bus_req_q  <= bus_req_d;
      cnt_q      <= cnt_d;
      flush_q    <= flush_d;
      if_data_q  <= if_data_d;
      if_valid_q <= if_valid_d;
      if_err_q   <= if_err_d;
      me_rdata_q <= me_rdata_d;
      me_valid_q <= me_valid_d;
      me_err_q   <= me_err_d;
    end
  end

  // Stalls release only in the granted port's RESP cycle; flush does not affect them.
  assign oStall_IF = iIF_req & ~((state_q == ARB_RESP) && (grant_q == GNT_IF));
  assign oStall_ME = iME_req & ~((state_q == ARB_RESP) && (grant_q == GNT_ME));

  assign oIF_data   = if_data_q;
  assign oIF_valid  = if_valid_q;
  assign oIF_err    = if_err_q;
  assign oME_rdata  = me_rdata_q;
  assign oME_valid  = me_valid_q;
  assign oME_err    = me_err_q;
  assign oBus_req   = bus_req_q;
  assign oBus_we    = bus_q.we;
  assign oBus_be    = bus_q.be;
  assign oBus_addr  = bus_q.addr;
  assign oBus_wdata = bus_q.wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter (TIMEOUT_CYCLES = 8).
module tb_mem_port_arbiter;

  logic        iClk = 1'b0;
  logic        nRst;
  logic        iIF_req;
  logic [31:0] iIF_addr;
  logic        iFlush_IF;
  logic [31:0] oIF_data;
  logic        oIF_valid, oIF_err, oStall_IF;
  logic        iME_req, iME_we;
  logic [3:0]  iME_be;
  logic [31:0] iME_addr, iME_wdata;
  logic [31:0] oME_rdata;
  logic        oME_valid, oME_err, oStall_ME;
  logic        oBus_req, oBus_we;
  logic [3:0]  oBus_be;
  logic [31:0] oBus_addr, oBus_wdata;
  logic        iBus_ack;
  logic [31:0] iBus_rdata;
  logic        iBus_err;

  mem_port_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .iClk(iClk), .nRst(nRst),
    .iIF_req(iIF_req), .iIF_addr(iIF_addr), .iFlush_IF(iFlush_IF),
    .oIF_data(oIF_data), .oIF_valid(oIF_valid), .oIF_err(oIF_err), .oStall_IF(oStall_IF),
    .iME_req(iME_req), .iME_we(iME_we), .iME_be(iME_be), .iME_addr(iME_addr),
    .iME_wdata(iME_wdata), .oME_rdata(oME_rdata), .oME_valid(oME_valid),
    .oME_err(oME_err), .oStall_ME(oStall_ME),
    .oBus_req(oBus_req), .oBus_we(oBus_we), .oBus_be(oBus_be), .oBus_addr(oBus_addr),
    .oBus_wdata(oBus_wdata), .iBus_ack(iBus_ack), .iBus_rdata(iBus_rdata), .iBus_err(iBus_err)
  );

  always #5 iClk = ~iClk;

  typedef struct packed {
    logic        ifq;
    logic [31:0] ifa;
    logic        fl;
    logic        meq;
    logic        mwe;
    logic [3:0]  mbe;
    logic [31:0] ma;
    logic [31:0] mwd;
    logic        ack;
    logic        berr;
    logic [31:0] rd;
  } in_t;

  typedef struct packed {
    logic        breq;
    logic        bwe;
    logic [3:0]  bbe;
    logic [31:0] badr;
    logic [31:0] bwd;
    logic        sif;
    logic        sme;
    logic        ivld;
    logic        ierr;
    logic        mvld;
    logic        merr;
    logic [31:0] dat;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  vec_t tv[$];
  in_t  ci;
  exp_t ce;
  int   total  = 0;
  int   passed = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s (vec %0d): got %h want %h", name, idx, act, exp);
  endtask

  task automatic add(input in_t i, input exp_t e);
    vec_t v;
    v.i = i;
    v.e = e;
    tv.push_back(v);
  endtask

  task automatic drive(input in_t i);
    iIF_req    = i.ifq;
    iIF_addr   = i.ifa;
    iFlush_IF  = i.fl;
    iME_req    = i.meq;
    iME_we     = i.mwe;
    iME_be     = i.mbe;
    iME_addr   = i.ma;
    iME_wdata  = i.mwd;
    iBus_ack   = i.ack;
    iBus_err   = i.berr;
    iBus_rdata = i.rd;
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic check_vec(input int idx, input exp_t e);
    chk("bus_req", idx, 32'(oBus_req), 32'(e.breq));
    chk("stall_if", idx, 32'(oStall_IF), 32'(e.sif));
    chk("stall_me", idx, 32'(oStall_ME), 32'(e.sme));
    chk("if_valid", idx, 32'(oIF_valid), 32'(e.ivld));
    chk("me_valid", idx, 32'(oME_valid), 32'(e.mvld));
    if (e.breq) begin
      chk("bus_we", idx, 32'(oBus_we), 32'(e.bwe));
      chk("bus_be", idx, 32'(oBus_be), 32'(e.bbe));
      chk("bus_addr", idx, oBus_addr, e.badr);
      if (e.bwe) chk("bus_wdata", idx, oBus_wdata, e.bwd);
    end
    if (e.ivld) begin
      chk("if_err", idx, 32'(oIF_err), 32'(e.ierr));
      chk("if_data", idx, oIF_data, e.dat);
    end
    if (e.mvld) begin
      chk("me_err", idx, 32'(oME_err), 32'(e.merr));
      chk("me_rdata", idx, oME_rdata, e.dat);
    end
  endtask

  // Expected-bus helpers for the vector tables
  function automatic exp_t bus_rd(input logic [31:0] a, input logic [3:0] be);
    exp_t e;
    e = '0;
    e.breq = 1'b1;
    e.bbe  = be;
    e.badr = a;
    return e;
  endfunction

  initial begin
    ci = '0;
    drive(ci);
    nRst = 1'b1;
    repeat (2) @(posedge iClk);
    #1;
    // Reset state
    chk("rst_bus_req", -1, 32'(oBus_req), 32'd0);
    chk("rst_if_valid", -1, 32'(oIF_valid), 32'd0);
    chk("rst_me_valid", -1, 32'(oME_valid), 32'd0);
    chk("rst_if_data", -1, oIF_data, 32'd0);
    chk("rst_me_rdata", -1, oME_rdata, 32'd0);
    chk("rst_bus_addr", -1, oBus_addr, 32'd0);
    chk("rst_stall_if", -1, 32'(oStall_IF), 32'd0);
    nRst = 1'b0;
    step();

    // 1: single fetch, ack in first BUS cycle
    ci = '0; ci.ifq = 1; ci.ifa = 32'h100;
    ce = '0; ce.sif = 1; add(ci, ce);
    ci.ack = 1; ci.rd = 32'hDEADBEEF;
    ce = bus_rd(32'h100, 4'hF); ce.sif = 1; add(ci, ce);
    ci.ack = 0;
    ce = '0; ce.ivld = 1; ce.dat = 32'hDEADBEEF; add(ci, ce);
    ci = '0; ce = '0; add(ci, ce);

    // 2: simultaneous IF + ME store, ME first, no preemption
    ci = '0; ci.ifq = 1; ci.ifa = 32'h104;
    ci.meq = 1; ci.mwe = 1; ci.mbe = 4'hF; ci.ma = 32'h2000; ci.mwd = 32'h12345678;
    ce = '0; ce.sif = 1; ce.sme = 1; add(ci, ce);
    ce = bus_rd(32'h2000, 4'hF); ce.bwe = 1; ce.bwd = 32'h12345678; ce.sif = 1; ce.sme = 1;
    add(ci, ce);
    ci.ack = 1; ci.rd = 32'hAAAA5555; add(ci, ce);
    ci.ack = 0;
    ce = '0; ce.sif = 1; ce.mvld = 1; ce.dat = 32'h0; add(ci, ce);
    ci.meq = 0; ci.mwe = 0;
    ce = '0; ce.sif = 1; add(ci, ce);
    ci.ack = 1; ci.rd = 32'h00001111;
    ce = bus_rd(32'h104, 4'hF); ce.sif = 1; add(ci, ce);
    ci.ack = 0;
    ce = '0; ce.ivld = 1; ce.dat = 32'h00001111; add(ci, ce);
    ci = '0; ce = '0; add(ci, ce);

    // 3: flushed fetch with 3 wait states, then redirected fetch
    ci = '0; ci.ifq = 1; ci.ifa = 32'h180;
    ce = '0; ce.sif = 1; add(ci, ce);
    ci.fl = 1;
    ce = bus_rd(32'h180, 4'hF); ce.sif = 1; add(ci, ce);
    ci.fl = 0; add(ci, ce); add(ci, ce);
    ci.ack = 1; ci.rd = 32'hBAD0BAD0; add(ci, ce);
    ci.ack = 0; ci.ifa = 32'h200;
    ce = '0; add(ci, ce);
    ce = '0; ce.sif = 1; add(ci, ce);
    ci.ack = 1; ci.rd = 32'h0C0FFEE0;
    ce = bus_rd(32'h200, 4'hF); ce.sif = 1; add(ci, ce);
    ci.ack = 0;
    ce = '0; ce.ivld = 1; ce.dat = 32'h0C0FFEE0; add(ci, ce);
    ci = '0; ce = '0; add(ci, ce);

    // 4a: ME load, no ack -> timeout after 8 BUS cycles
    ci = '0; ci.meq = 1; ci.mbe = 4'hF; ci.ma = 32'h3000;
    ce = '0; ce.sme = 1; add(ci, ce);
    for (int k = 0; k < 8; k++) begin
      ce = bus_rd(32'h3000, 4'hF); ce.sme = 1; add(ci, ce);
    end
    ce = '0; ce.mvld = 1; ce.merr = 1; ce.dat = 32'h0; add(ci, ce);
    ci = '0; ce = '0; add(ci, ce);

    // 4b: ack on the 8th BUS cycle counts as ack; IF flush ignored for ME
    ci = '0; ci.meq = 1; ci.mbe = 4'hF; ci.ma = 32'h3004;
    ce = '0; ce.sme = 1; add(ci, ce);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) begin ci.ack = 1; ci.rd = 32'h55AA55AA; ci.fl = 1; end
      ce = bus_rd(32'h3004, 4'hF); ce.sme = 1; add(ci, ce);
    end
    ci.ack = 0; ci.fl = 0;
    ce = '0; ce.mvld = 1; ce.dat = 32'h55AA55AA; add(ci, ce);
    ci = '0; ce = '0; add(ci, ce);

    // 5: ME load with slave error, then normal fetch
    ci = '0; ci.meq = 1; ci.mbe = 4'h3; ci.ma = 32'h4000;
    ce = '0; ce.sme = 1; add(ci, ce);
    ci.ack = 1; ci.berr = 1; ci.rd = 32'h11112222;
    ce = bus_rd(32'h4000, 4'h3); ce.sme = 1; add(ci, ce);
    ci.ack = 0; ci.berr = 0; ci.ifq = 1; ci.ifa = 32'h300;
    ce = '0; ce.sif = 1; ce.mvld = 1; ce.merr = 1; ce.dat = 32'h11112222; add(ci, ce);
    ci.meq = 0;
    ce = '0; ce.sif = 1; add(ci, ce);
    ci.ack = 1; ci.rd = 32'h33334444;
    ce = bus_rd(32'h300, 4'hF); ce.sif = 1; add(ci, ce);
    ci.ack = 0;
    ce = '0; ce.ivld = 1; ce.dat = 32'h33334444; add(ci, ce);
    ci = '0; ce = '0; add(ci, ce);

    foreach (tv[n]) begin
      drive(tv[n].i);
      #2;
      check_vec(n, tv[n].e);
      step();
    end

    // 6: reset while in BUS abandons the transaction
    ci = '0; ci.ifq = 1; ci.ifa = 32'h500;
    drive(ci);
    step();
    chk("r6_bus_req_on", 100, 32'(oBus_req), 32'd1);
    chk("r6_bus_addr", 100, oBus_addr, 32'h500);
    nRst = 1'b1;
    ci = '0; drive(ci);
    step();
    chk("r6_bus_req_off", 101, 32'(oBus_req), 32'd0);
    chk("r6_if_valid", 101, 32'(oIF_valid), 32'd0);
    chk("r6_me_valid", 101, 32'(oME_valid), 32'd0);
    chk("r6_stall_if", 101, 32'(oStall_IF), 32'd0);
    chk("r6_stall_me", 101, 32'(oStall_ME), 32'd0);
    nRst = 1'b0;
    ci.ack = 1; ci.rd = 32'hFEEDFACE; drive(ci);
    step();
    chk("r6_stray_ack_valid", 102, 32'(oIF_valid), 32'd0);
    chk("r6_stray_ack_req", 102, 32'(oBus_req), 32'd0);
    // Fresh fetch proves the FSM restarted from IDLE
    ci = '0; ci.ifq = 1; ci.ifa = 32'h600; drive(ci);
    step();
    chk("r6_refetch_req", 103, 32'(oBus_req), 32'd1);
    chk("r6_refetch_addr", 103, oBus_addr, 32'h600);
    ci.ack = 1; ci.rd = 32'h600D600D; drive(ci);
    step();
    ci = '0; drive(ci);
    #1;
    chk("r6_refetch_valid", 104, 32'(oIF_valid), 32'd1);
    chk("r6_refetch_data", 104, oIF_data, 32'h600D600D);
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
